mul_add: RTL and testbench

//   Sequential shift-and-add multiply-accumulate: result = multiplicand * multiplier + addend.

---
 rtl/mul_add.sv | 102 ++++++++++
 tb/tb_mul_add.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_add.sv
// mul_add: sequential shift-and-add multiply-accumulate.
// Computes result = multiplicand * multiplier + addend, consuming one
// multiplier bit per clock (LSB first). Fixed latency of WIDTH cycles
// after the start edge; done then holds the result until the next start.
//
// Handshake: start is a level sampled on every rising edge. Each edge
// that sees start=1 loads fresh operands and (re)starts the operation,
// discarding any operation in flight. done=1 marks result as valid and
// stays high until the next start edge or reset. The result output is
// only meaningful while done=1.

`ifndef WIDTH
`define WIDTH 4
`endif

module mul_add #(
  parameter int WIDTH = `WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [1:0]         dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [CW-1:0]        count_q, count_d;

  // State and datapath registers; reset aborts any operation and clears all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath: start always wins; BUSY does one add/shift step.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    count_d = count_q;

    if (start) begin
      state_d = S_BUSY;
      acc_d   = {{WIDTH{1'b0}}, addend};
      mcand_d = {{WIDTH{1'b0}}, multiplicand};
      mplr_d  = multiplier;
      count_d = '0;
    end else begin
      case (state_q)
        S_BUSY: begin
          // The final sum is at most 2^2W - 2^W, so this add never carries out.
          if (mplr_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          count_d = count_q + CW'(1);
          if (count_q == LAST_CNT) begin
            state_d = S_DONE;
          end
        end
        default: begin
          // IDLE and DONE hold everything until the next start.
          state_d = state_q;
        end
      endcase
    end
  end

  assign done        = (state_q == S_DONE);
  assign result      = acc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_add.sv
// Testbench for mul_add: directed vector table and multi-cycle sequences on
// a WIDTH=4 instance, randomized operations on a WIDTH=8 instance checked
// against plain arithmetic A*B+C.
`timescale 1ns/1ps

module tb_mul_add;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT, WIDTH=4 ----------------
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, c4 = '0;
  logic       done4;
  logic [7:0] res4;
  logic [1:0] st4;

  mul_add #(.WIDTH(4)) u_w4 (
    .clk          (clk),
    .rst          (rst),
    .start        (start4),
    .multiplicand (a4),
    .multiplier   (b4),
    .addend       (c4),
    .done         (done4),
    .result       (res4),
    .dbg_state_o  (st4)
  );

  // ---------------- DUT, WIDTH=8 ----------------
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, c8 = '0;
  logic        done8;
  logic [15:0] res8;
  logic [1:0]  st8;

  mul_add #(.WIDTH(8)) u_w8 (
    .clk          (clk),
    .rst          (rst),
    .start        (start8),
    .multiplicand (a8),
    .multiplier   (b8),
    .addend       (c8),
    .done         (done8),
    .result       (res8),
    .dbg_state_o  (st8)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (WIDTH=4) ----------------
  // Presents operands with start=1 for exactly one rising edge.
  task automatic start_op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; c4 = c;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom_range(0, 15));
    b4 = 4'($urandom_range(0, 15));
    c4 = 4'($urandom_range(0, 15));
  endtask

  // After the start edge, done must stay low for 3 edges and rise on the 4th.
  // Called right after start_op4 (we are at the negedge following the start edge).
  task automatic expect_latency4(input string name, input logic [7:0] exp);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk({name, " done low"}, done4, 0);
    end
    @(posedge clk); #1;
    chk({name, " done high"}, done4, 1);
    chk({name, " result"}, res4, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc;
    logic [7:0] held;

    vecs[0] = '{a: 4'd13, b: 4'd11, c: 4'd7,  exp: 8'd150};
    vecs[1] = '{a: 4'd15, b: 4'd15, c: 4'd15, exp: 8'd240};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  c: 4'd9,  exp: 8'd9};
    vecs[3] = '{a: 4'd15, b: 4'd0,  c: 4'd0,  exp: 8'd0};
    vecs[4] = '{a: 4'd1,  b: 4'd1,  c: 4'd0,  exp: 8'd1};
    vecs[5] = '{a: 4'd15, b: 4'd1,  c: 4'd15, exp: 8'd30};
    vecs[6] = '{a: 4'd7,  b: 4'd9,  c: 4'd3,  exp: 8'd66};
    vecs[7] = '{a: 4'd8,  b: 4'd8,  c: 4'd0,  exp: 8'd64};

    // ---- reset state ----
    #1;
    chk("reset done", done4, 0);
    chk("reset result", res4, 0);
    chk("reset done w8", done8, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Idle after reset: no spontaneous done.
    repeat (6) @(posedge clk);
    #1;
    chk("idle after reset done", done4, 0);
    chk("idle after reset result", res4, 0);

    // ---- table vectors ----
    foreach (vecs[i]) begin
      start_op4(vecs[i].a, vecs[i].b, vecs[i].c);
      expect_latency4($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---- result held while idle (last vec: 64), operands wiggling ----
    held = 8'd64;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      c4 = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      chk("hold done", done4, 1);
      chk("hold result", res4, held);
    end

    // ---- async reset mid-operation ----
    start_op4(4'd13, 4'd11, 4'd7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midop rst done", done4, 0);
    chk("midop rst result", res4, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post rst idle done", done4, 0);
    chk("post rst idle result", res4, 0);

    // ---- restart while busy ----
    start_op4(4'd3, 4'd5, 4'd0);      // start edge N
    @(posedge clk); #1;                 // edge N+1
    chk("restart e1 done", done4, 0);
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd2; c4 = 4'd1;
    @(posedge clk); #1;                 // edge N+2: restart
    chk("restart e2 done", done4, 0);
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("restart e%0d done", k), done4, 0);
    end
    @(posedge clk); #1;                 // edge N+6
    chk("restart e6 done", done4, 1);
    chk("restart result", res4, 15);

    // ---- back-to-back: start on the cycle done is high ----
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd6; c4 = 4'd2;
    @(posedge clk); #1;
    chk("b2b done drops", done4, 0);
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("b2b done low", done4, 0);
    end
    @(posedge clk); #1;
    chk("b2b done high", done4, 1);
    chk("b2b result", res4, 56);

    // ---- start held high keeps done low ----
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd2; b4 = 4'd3; c4 = 4'd4;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("held start done", done4, 0);
    end
    @(negedge clk);
    start4 = 1'b0;
    expect_latency4("after held start", 8'd10);

    // ---- randomized WIDTH=8 against A*B+C ----
    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra, rb, rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      if (n == 0) begin ra = 8'hFF; rb = 8'hFF; rc = 8'hFF; end
      if (n == 1) begin ra = 8'h00; rb = 8'hFF; rc = 8'h00; end
      exp_q.push_back(16'(int'(ra) * int'(rb) + int'(rc)));
      @(negedge clk);
      start8 = 1'b1; a8 = ra; b8 = rb; c8 = rc;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
      cyc = 0;
      // The start edge has passed; count edges until done, bounded.
      while (cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        if (done8) break;
      end
      chk("w8 latency", cyc, 8);
      chk("w8 result", res8, exp_q.pop_front());
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk("w8 held", {done8, res8}, {1'b1, 16'(int'(ra) * int'(rb) + int'(rc))});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
